sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param_if.sv | 33 +++
 rtl/sync_fifo_param.sv | 89 ++++++++
 tb/tb_sync_fifo_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Bundle of the FIFO write/read handshake and status signals.
// master: the producer/consumer side; slave: the FIFO itself.
interface sync_fifo_param_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read port, threshold flags and sticky
// overflow/underflow. Pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_param_if.slave fifo
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PtrOne = PW'(1);

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             full;
    logic             empty;
    logic             rd_acc;
    logic             wr_acc;
    logic [PW-1:0]    count;

    // Status decode and acceptance; a full FIFO still takes a write when a
    // read frees an entry at the same edge.
    always_comb begin
        full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty  = (wr_ptr_q == rd_ptr_q);
        count  = wr_ptr_q - rd_ptr_q;
        rd_acc = fifo.rd_en && !empty;
        wr_acc = fifo.wr_en && (!full || rd_acc);
    end

    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.count        = count;
    assign fifo.almost_full  = (32'(count) >= AF_LEVEL);
    assign fifo.almost_empty = (32'(count) <= AE_LEVEL);
    assign fifo.rd_data      = rd_data_q;
    assign fifo.rd_valid     = rd_valid_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;

    // Storage array: cleared on reset, written at the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= fifo.wr_data;
        end
    end

    // Pointers, registered read port and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + PtrOne;
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
            if (fifo.wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (fifo.rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed table on the default 3-bit x 8 FIFO,
// a wrap sequence, randomized traffic against a queue model, and a reset
// sequence on a 16-bit x 4 instance.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic reset8;
    logic reset16;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(3), .DEPTH(8)) f8 ();
    sync_fifo_param_if #(.WIDTH(16), .DEPTH(4)) f16 ();

    sync_fifo_param #(.WIDTH(3), .DEPTH(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .fifo  (f8)
    );

    sync_fifo_param #(.WIDTH(16), .DEPTH(4)) dut16 (
        .clk   (clk),
        .reset (reset16),
        .fifo  (f16)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a queue of words plus the observable side registers.
    bit [2:0] mq[$];
    bit       m_ovf;
    bit       m_udf;
    bit       m_rdv;
    bit [2:0] m_rdd;

    typedef struct {
        bit       rst;
        bit       we;
        bit [2:0] wd;
        bit       re;
        int       cnt;
        bit       full;
        bit       empty;
        bit       af;
        bit       ae;
        bit       rdv;
        bit [2:0] rdd;
        bit       ovf;
        bit       udf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit we, int wd, bit re, int cnt, bit rdv, int rdd,
                                bit ovf, bit udf);
        vec_t v;
        v.rst   = rst;
        v.we    = we;
        v.wd    = 3'(wd);
        v.re    = re;
        v.cnt   = cnt;
        v.full  = (cnt == 8);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 7);
        v.ae    = (cnt <= 1);
        v.rdv   = rdv;
        v.rdd   = 3'(rdd);
        v.ovf   = ovf;
        v.udf   = udf;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_step(bit rst, bit we, bit [2:0] wd, bit re);
        bit do_rd;
        bit do_wr;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rdv = 1'b0;
            m_rdd = '0;
            return;
        end
        do_rd = re && (mq.size() > 0);
        do_wr = we && ((mq.size() < 8) || do_rd);
        if (re && mq.size() == 0) m_udf = 1'b1;
        if (we && !do_wr) m_ovf = 1'b1;
        if (do_rd) begin
            m_rdd = mq.pop_front();
            m_rdv = 1'b1;
        end else begin
            m_rdv = 1'b0;
        end
        if (do_wr) mq.push_back(wd);
    endfunction

    // Drive one cycle on the 8-deep FIFO; outputs are sampled 1ns after the edge.
    task automatic apply(bit rst, bit we, bit [2:0] wd, bit re);
        reset8     = rst;
        f8.wr_en   = we;
        f8.wr_data = wd;
        f8.rd_en   = re;
        model_step(rst, we, wd, re);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, " count"}, int'(f8.count), mq.size());
        chk({tag, " full"}, int'(f8.full), int'(mq.size() == 8));
        chk({tag, " empty"}, int'(f8.empty), int'(mq.size() == 0));
        chk({tag, " almost_full"}, int'(f8.almost_full), int'(mq.size() >= 7));
        chk({tag, " almost_empty"}, int'(f8.almost_empty), int'(mq.size() <= 1));
        chk({tag, " rd_valid"}, int'(f8.rd_valid), int'(m_rdv));
        chk({tag, " rd_data"}, int'(f8.rd_data), int'(m_rdd));
        chk({tag, " overflow"}, int'(f8.overflow), int'(m_ovf));
        chk({tag, " underflow"}, int'(f8.underflow), int'(m_udf));
    endtask

    task automatic apply16(bit rst, bit we, bit [15:0] wd, bit re);
        reset16     = rst;
        f16.wr_en   = we;
        f16.wr_data = wd;
        f16.rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wprob;
        reset8      = 1'b1;
        reset16     = 1'b1;
        f8.wr_en    = 1'b0;
        f8.wr_data  = '0;
        f8.rd_en    = 1'b0;
        f16.wr_en   = 1'b0;
        f16.wr_data = '0;
        f16.rd_en   = 1'b0;

        // Directed table: fill to full, overflow, drain, underflow, empty write+read.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, k, 0, k, 0, 0, 0, 0);
        add(0, 1, 9, 0, 8, 0, 0, 1, 0);
        // Word 8 is stored as 0 in a 3-bit FIFO.
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 8 - k, 1, k % 8, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 5, 1, 1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1, 5, 1, 1);
        add(0, 0, 0, 0, 0, 0, 5, 1, 1);
        add(0, 0, 0, 1, 0, 0, 5, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].re);
            chk($sformatf("tbl%0d count", i), int'(f8.count), tbl[i].cnt);
            chk($sformatf("tbl%0d full", i), int'(f8.full), int'(tbl[i].full));
            chk($sformatf("tbl%0d empty", i), int'(f8.empty), int'(tbl[i].empty));
            chk($sformatf("tbl%0d almost_full", i), int'(f8.almost_full), int'(tbl[i].af));
            chk($sformatf("tbl%0d almost_empty", i), int'(f8.almost_empty), int'(tbl[i].ae));
            chk($sformatf("tbl%0d rd_valid", i), int'(f8.rd_valid), int'(tbl[i].rdv));
            chk($sformatf("tbl%0d rd_data", i), int'(f8.rd_data), int'(tbl[i].rdd));
            chk($sformatf("tbl%0d overflow", i), int'(f8.overflow), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d underflow", i), int'(f8.underflow), int'(tbl[i].udf));
        end

        // Full FIFO with simultaneous read+write for 20 cycles: pointers wrap,
        // count stays at 8, old words drain in order then the new ones appear.
        apply(1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) apply(0, 1, 3'(k), 0);
        for (int c = 0; c < 20; c++) begin
            apply(0, 1, 3'(10), 1);
            chk($sformatf("wrap%0d count", c), int'(f8.count), 8);
            chk($sformatf("wrap%0d rd_data", c), int'(f8.rd_data), (c < 8) ? ((c + 1) % 8) : 2);
            check_model($sformatf("wrap%0d", c));
        end

        // Randomized traffic with phases of fill-biased, drain-biased and balanced load.
        apply(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 3)
                0:       wprob = 75;
                1:       wprob = 25;
                default: wprob = 50;
            endcase
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < wprob,
                  3'($urandom),
                  $urandom_range(0, 99) < (100 - wprob));
            check_model($sformatf("rnd%0d", c));
        end

        // 16-bit x 4 instance: reset with a write pending clears everything.
        apply16(1, 0, 16'h0, 0);
        apply16(0, 0, 16'h0, 1);
        chk("w16 underflow set", int'(f16.underflow), 1);
        apply16(0, 1, 16'h1234, 0);
        apply16(0, 1, 16'hBEEF, 0);
        apply16(0, 1, 16'h00F0, 0);
        chk("w16 count 3", int'(f16.count), 3);
        chk("w16 almost_full", int'(f16.almost_full), 1);
        apply16(0, 0, 16'h0, 1);
        chk("w16 rd_data", int'(f16.rd_data), 16'h1234);
        chk("w16 rd_valid", int'(f16.rd_valid), 1);
        chk("w16 count 2", int'(f16.count), 2);
        apply16(1, 1, 16'hFFFF, 1);
        chk("w16 rst count", int'(f16.count), 0);
        chk("w16 rst empty", int'(f16.empty), 1);
        chk("w16 rst full", int'(f16.full), 0);
        chk("w16 rst rd_data", int'(f16.rd_data), 0);
        chk("w16 rst rd_valid", int'(f16.rd_valid), 0);
        chk("w16 rst overflow", int'(f16.overflow), 0);
        chk("w16 rst underflow", int'(f16.underflow), 0);
        chk("w16 rst almost_empty", int'(f16.almost_empty), 1);
        chk("w16 rst almost_full", int'(f16.almost_full), 0);
        apply16(0, 0, 16'h0, 0);
        chk("w16 post count", int'(f16.count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
